// File: rtl/nmi_arbiter_pkg.sv
// Shared types and constants for the NMI round-robin arbiter.
package nmi_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned NMI_AW = 32;
    localparam int unsigned NMI_DW = 32;
    localparam int unsigned NMI_SW = 4;

    localparam logic [NMI_DW-1:0] TMO_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/nmi_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NUM_MST.
module nmi_rr_picker
    import nmi_arb_pkg::*;
#(
    parameter int unsigned NUM_MST = 2,
    parameter int unsigned IDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_MST-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NUM_MST; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NUM_MST);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin arbiter sharing one NMI slave port between NUM_MST masters.
// Optional forced termination of stalled transactions with NMI_ARB_TIMEOUT_EN.
module nmi_arbiter
    import nmi_arb_pkg::*;
#(
    parameter int unsigned NUM_MST     = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_MST-1:0]        m_valid_i,
    input  logic [NUM_MST-1:0]        m_instr_i,
    input  logic [NUM_MST*NMI_AW-1:0] m_addr_i,
    input  logic [NUM_MST*NMI_DW-1:0] m_wdata_i,
    input  logic [NUM_MST*NMI_SW-1:0] m_wstrb_i,
    output logic [NUM_MST-1:0]        m_ready_o,
    output logic [NUM_MST*NMI_DW-1:0] m_rdata_o,
    output logic                      s_valid_o,
    output logic                      s_instr_o,
    output logic [NMI_AW-1:0]         s_addr_o,
    output logic [NMI_DW-1:0]         s_wdata_o,
    output logic [NMI_SW-1:0]         s_wstrb_o,
    input  logic                      s_ready_i,
    input  logic [NMI_DW-1:0]         s_rdata_i,
    output logic [NUM_MST-1:0]        gnt_o,
    output logic                      busy_o,
    output logic                      tmo_o
);

    localparam int unsigned IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, ptr_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic [NUM_MST-1:0] pick_gnt;
    logic             busy, gnt_valid, done, tmo_hit;

    nmi_rr_picker #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (m_valid_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign busy      = (state_q == BUSY);
    assign gnt_valid = m_valid_i[gnt_idx_q];
    // A ready seen while the granted master has dropped valid is not a completion.
    assign done      = busy && gnt_valid && s_ready_i;
    assign ptr_nxt   = (gnt_idx_q == IDX_W'(NUM_MST - 1)) ? '0 : gnt_idx_q + 1'b1;

`ifdef NMI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (!busy)
                tmo_cnt_q <= '0;
            else if (!s_ready_i)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_hit)
                tmo_q <= 1'b1;
        end
    end

    assign tmo_hit = busy && !done && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));
    assign tmo_o   = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|m_valid_i) begin
                    gnt_idx_d = pick_idx;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (done || tmo_hit) begin
                    ptr_d   = ptr_nxt;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_o     = '0;
        m_ready_o = '0;
        m_rdata_o = '0;
        s_valid_o = 1'b0;
        s_instr_o = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_wstrb_o = '0;
        busy_o    = busy;
        if (busy) begin
            gnt_o[gnt_idx_q]     = 1'b1;
            s_valid_o            = gnt_valid && !tmo_hit;
            s_instr_o            = m_instr_i[gnt_idx_q];
            s_addr_o             = m_addr_i[gnt_idx_q*NMI_AW +: NMI_AW];
            s_wdata_o            = m_wdata_i[gnt_idx_q*NMI_DW +: NMI_DW];
            s_wstrb_o            = m_wstrb_i[gnt_idx_q*NMI_SW +: NMI_SW];
            m_ready_o[gnt_idx_q] = done || tmo_hit;
            m_rdata_o[gnt_idx_q*NMI_DW +: NMI_DW] = tmo_hit ? TMO_RDATA : s_rdata_i;
        end
    end

endmodule

// File: tb/tb_nmi_arbiter.sv
// Self-checking bench for nmi_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level reference model.
module tb_nmi_arbiter;

    localparam int N    = 2;
    localparam int TCYC = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      m_valid_i, m_instr_i;
    logic [N*32-1:0]   m_addr_i, m_wdata_i;
    logic [N*4-1:0]    m_wstrb_i;
    logic [N-1:0]      m_ready_o;
    logic [N*32-1:0]   m_rdata_o;
    logic              s_valid_o, s_instr_o;
    logic [31:0]       s_addr_o, s_wdata_o;
    logic [3:0]        s_wstrb_o;
    logic              s_ready_i;
    logic [31:0]       s_rdata_i;
    logic [N-1:0]      gnt_o;
    logic              busy_o, tmo_o;

    always #5 clk = ~clk;

    nmi_arbiter #(.NUM_MST(N), .TIMEOUT_CYC(TCYC)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_valid_i(m_valid_i), .m_instr_i(m_instr_i), .m_addr_i(m_addr_i),
        .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
        .m_ready_o(m_ready_o), .m_rdata_o(m_rdata_o),
        .s_valid_o(s_valid_o), .s_instr_o(s_instr_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
        .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .tmo_o(tmo_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whose turn is next, how long the slave has stalled.
    bit     mdl_busy;
    int     mdl_owner;
    int     mdl_ptr;
    int     mdl_wait;
    bit     mdl_tmo;
    bit     mdl_tmo_now;
    logic [N-1:0] exp_ready;

    task automatic model_reset();
        mdl_busy = 0; mdl_owner = 0; mdl_ptr = 0; mdl_wait = 0; mdl_tmo = 0;
        mdl_tmo_now = 0; exp_ready = '0;
    endtask

    task automatic compare_outputs();
        logic [N-1:0]    e_gnt;
        logic [N*32-1:0] e_rdata;
        logic            e_valid;
        logic [31:0]     e_addr, e_wdata;
        logic [3:0]      e_wstrb;
        logic            e_instr;
        e_gnt = '0; e_rdata = '0; e_valid = 0; e_addr = '0; e_wdata = '0;
        e_wstrb = '0; e_instr = 0; exp_ready = '0; mdl_tmo_now = 0;
        if (mdl_busy) begin
`ifdef NMI_ARB_TIMEOUT_EN
            mdl_tmo_now = (mdl_wait == TCYC) && !(m_valid_i[mdl_owner] && s_ready_i);
`endif
            e_gnt[mdl_owner] = 1'b1;
            e_valid = m_valid_i[mdl_owner] && !mdl_tmo_now;
            e_instr = m_instr_i[mdl_owner];
            e_addr  = m_addr_i[mdl_owner*32 +: 32];
            e_wdata = m_wdata_i[mdl_owner*32 +: 32];
            e_wstrb = m_wstrb_i[mdl_owner*4 +: 4];
            exp_ready[mdl_owner] = (e_valid && s_ready_i) || mdl_tmo_now;
            e_rdata[mdl_owner*32 +: 32] = mdl_tmo_now ? 32'hDEAD_BEEF : s_rdata_i;
        end
        check_eq("gnt",     64'(gnt_o),     64'(e_gnt));
        check_eq("busy",    64'(busy_o),    64'(mdl_busy));
        check_eq("s_valid", 64'(s_valid_o), 64'(e_valid));
        check_eq("s_instr", 64'(s_instr_o), 64'(e_instr));
        check_eq("s_addr",  64'(s_addr_o),  64'(e_addr));
        check_eq("s_wdata", 64'(s_wdata_o), 64'(e_wdata));
        check_eq("s_wstrb", 64'(s_wstrb_o), 64'(e_wstrb));
        check_eq("m_ready", 64'(m_ready_o), 64'(exp_ready));
        check_eq("m_rdata", 64'(m_rdata_o), 64'(e_rdata));
        check_eq("tmo",     64'(tmo_o),     64'(mdl_tmo));
    endtask

    task automatic model_update();
        if (rst_i) begin
            model_reset();
        end else if (!mdl_busy) begin
            if (|m_valid_i) begin
                for (int off = N - 1; off >= 0; off--)
                    if (m_valid_i[(mdl_ptr + off) % N]) mdl_owner = (mdl_ptr + off) % N;
                mdl_busy = 1;
                mdl_wait = 0;
            end
        end else if (exp_ready != '0) begin
            mdl_ptr  = (mdl_owner + 1) % N;
            mdl_busy = 0;
            if (mdl_tmo_now) mdl_tmo = 1;
        end else if (!s_ready_i) begin
            mdl_wait++;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_i) model_reset();
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        m_valid_i = '0; m_instr_i = '0; m_addr_i = '0; m_wdata_i = '0; m_wstrb_i = '0;
        s_ready_i = 0; s_rdata_i = '0;
    endtask

    bit [N-1:0] pend;
    int         exp_m;

    initial begin
        idle_inputs();
        rst_i = 1;
        model_reset();
        tick(); tick();
        rst_i = 0;
        tick();

        // Single-master read with a 3-cycle slave.
        m_valid_i = 2'b01; m_addr_i[31:0] = 32'h0300_0000;
        #1 check_eq("t1_idle_valid", 64'(s_valid_o), 64'd0);
        tick();
        #1 check_eq("t1_valid_rise", 64'(s_valid_o), 64'd1);
        check_eq("t1_addr", 64'(s_addr_o), 64'h0300_0000);
        tick(); tick();
        s_ready_i = 1; s_rdata_i = 32'h1234_5678;
        #1 check_eq("t1_ready", 64'(m_ready_o), 64'b01);
        check_eq("t1_rdata", 64'(m_rdata_o[31:0]), 64'h1234_5678);
        tick();
        idle_inputs();
        #1 check_eq("t1_bubble", 64'(m_ready_o), 64'd0);
        tick();

        // Both masters streaming, slave always ready: pointer is 1, so m1 then m0 alternate.
        m_valid_i = 2'b11; s_ready_i = 1;
        exp_m = 1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (m_ready_o != '0) begin
                check_eq("rr_seq", 64'(m_ready_o), 64'(1 << exp_m));
                exp_m = 1 - exp_m;
            end
            tick();
        end
        idle_inputs();
        tick();

        // Simultaneous requests with pointer at 1; m1 writes, m0 waits for the ready pulse.
        m_valid_i = 2'b11;
        m_wdata_i[63:32] = 32'hAABB_CCDD; m_wstrb_i[7:4] = 4'b0011;
        tick();
        #1 check_eq("t3_gnt_m1", 64'(gnt_o), 64'b10);
        check_eq("t3_wstrb", 64'(s_wstrb_o), 64'b0011);
        check_eq("t3_wdata", 64'(s_wdata_o), 64'hAABB_CCDD);
        tick();
        s_ready_i = 1;
        #1 check_eq("t3_ready_m1", 64'(m_ready_o), 64'b10);
        tick();
        m_valid_i = 2'b01; s_ready_i = 0;
        #1 check_eq("t3_m0_held", 64'(gnt_o), 64'd0);
        tick();
        #1 check_eq("t3_gnt_m0", 64'(gnt_o), 64'b01);
        s_ready_i = 1;
        tick();
        idle_inputs();
        tick();

        // Reset while the slave stalls m1; afterwards m0 is served first.
        m_valid_i = 2'b10;
        tick(); tick();
        rst_i = 1;
        #1 check_eq("rst_gnt", 64'(gnt_o), 64'd0);
        check_eq("rst_valid", 64'(s_valid_o), 64'd0);
        check_eq("rst_ready", 64'(m_ready_o), 64'd0);
        tick();
        rst_i = 0; m_valid_i = 2'b11;
        tick();
        #1 check_eq("rst_m0_first", 64'(gnt_o), 64'b01);
        s_ready_i = 1;
        tick();
        idle_inputs();
        tick();

`ifdef NMI_ARB_TIMEOUT_EN
        // Stalled slave: forced completion after TCYC waiting cycles, then normal service.
        m_valid_i = 2'b01;
        tick();
        for (int c = 0; c < TCYC; c++) begin
            #1 check_eq("tmo_wait", 64'(m_ready_o), 64'd0);
            tick();
        end
        #1 check_eq("tmo_ready", 64'(m_ready_o), 64'b01);
        check_eq("tmo_rdata", 64'(m_rdata_o[31:0]), 64'hDEAD_BEEF);
        check_eq("tmo_valid", 64'(s_valid_o), 64'd0);
        tick();
        m_valid_i = 2'b10;
        #1 check_eq("tmo_sticky", 64'(tmo_o), 64'd1);
        tick();
        s_ready_i = 1;
        #1 check_eq("tmo_next_m1", 64'(m_ready_o), 64'b10);
        tick();
        idle_inputs();
        tick();
`else
        check_eq("tmo_tied", 64'(tmo_o), 64'd0);
`endif

        // Randomized traffic obeying the hold-until-ready rule.
        pend = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (pend[k] && exp_ready[k]) pend[k] = 0;
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1;
                    m_instr_i[k] = 1'($urandom_range(0, 1));
                    m_addr_i[k*32 +: 32]  = $urandom;
                    m_wdata_i[k*32 +: 32] = $urandom;
                    m_wstrb_i[k*4 +: 4]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                end
            end
            m_valid_i = pend;
            s_ready_i = ($urandom_range(0, 9) < 4);
            s_rdata_i = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
